// File: rtl/recog_frame_sched.sv
// Frame scheduler for the digit recognizer.
// Sequences projection, border and feature frames on synchronized vsync
// edges and validates the projection row/column counts before they are
// handed to the recognizer. Rejected frames are retried up to MAX_RETRY
// times before the run is abandoned with a sticky abort flag.
module recog_frame_sched #(
  parameter int MAX_ROW   = 1,
  parameter int MAX_COL   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       start,
  input  logic       cont_mode,
  input  logic       proj_valid,
  input  logic [3:0] proj_num_row,
  input  logic [3:0] proj_num_col,
  output logic [1:0] frame_cnt,
  output logic       project_done_flag,
  output logic [3:0] num_row,
  output logic [3:0] num_col,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       abort
);

  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [3:0]    ROW_LIM    = 4'(MAX_ROW);
  localparam logic [3:0]    COL_LIM    = 4'(MAX_COL);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_PROJ,
    S_BORDER,
    S_FEATURE
  } state_e;

  // Reset synchronizer: assertion is immediate, release follows clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  // vsync crossing: two-flop synchronizer, one edge-detect register, and a
  // priming shift register that hides any edge formed by the pipeline
  // filling up right after reset (e.g. vsync already high at release).
  logic       vs_meta_q;
  logic       vs_sync_q;
  logic       vs_prev_q;
  logic [2:0] prime_q;
  logic       vs_rise;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      vs_meta_q <= 1'b0;
      vs_sync_q <= 1'b0;
      vs_prev_q <= 1'b0;
      prime_q   <= 3'b000;
    end else begin
      vs_meta_q <= vsync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      prime_q   <= {prime_q[1:0], 1'b1};
    end
  end

  assign vs_rise = prime_q[2] & vs_sync_q & ~vs_prev_q;

  // Frame-close view of the projection counts: a proj_valid arriving in the
  // same cycle as the closing edge belongs to the frame being closed.
  logic       shadow_seen_q;
  logic [3:0] shadow_row_q;
  logic [3:0] shadow_col_q;
  logic       eff_seen;
  logic [3:0] eff_row;
  logic [3:0] eff_col;
  logic       accept;

  assign eff_seen = shadow_seen_q | proj_valid;
  assign eff_row  = proj_valid ? proj_num_row : shadow_row_q;
  assign eff_col  = proj_valid ? proj_num_col : shadow_col_q;
  assign accept   = eff_seen
                  && (eff_row != 4'd0) && (eff_row <= ROW_LIM)
                  && (eff_col != 4'd0) && (eff_col <= COL_LIM);

  state_e        state_q;
  logic [1:0]    frame_cnt_q;
  logic          pdf_q;
  logic [3:0]    num_row_q;
  logic [3:0]    num_col_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic          abort_q;
  logic [RW-1:0] retry_q;

  // Scheduler FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= S_IDLE;
      frame_cnt_q   <= 2'd0;
      pdf_q         <= 1'b0;
      num_row_q     <= 4'd0;
      num_col_q     <= 4'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      abort_q       <= 1'b0;
      retry_q       <= '0;
      shadow_seen_q <= 1'b0;
      shadow_row_q  <= 4'd0;
      shadow_col_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_WAIT_SYNC;
            busy_q  <= 1'b1;
            abort_q <= 1'b0;
          end
        end
        S_WAIT_SYNC: begin
          if (vs_rise) begin
            state_q       <= S_PROJ;
            shadow_seen_q <= 1'b0;
            shadow_row_q  <= 4'd0;
            shadow_col_q  <= 4'd0;
          end
        end
        S_PROJ: begin
          if (vs_rise) begin
            // Every frame close starts the next projection frame clean.
            shadow_seen_q <= 1'b0;
            shadow_row_q  <= 4'd0;
            shadow_col_q  <= 4'd0;
            if (accept) begin
              num_row_q   <= eff_row;
              num_col_q   <= eff_col;
              retry_q     <= '0;
              state_q     <= S_BORDER;
              frame_cnt_q <= 2'd1;
              pdf_q       <= 1'b1;
            end else begin
              err_q <= 1'b1;
              if (retry_q == RETRY_LAST) begin
                retry_q <= '0;
                abort_q <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                retry_q <= retry_q + 1'b1;
              end
            end
          end else if (proj_valid) begin
            shadow_seen_q <= 1'b1;
            shadow_row_q  <= proj_num_row;
            shadow_col_q  <= proj_num_col;
          end
        end
        S_BORDER: begin
          if (vs_rise) begin
            state_q     <= S_FEATURE;
            frame_cnt_q <= 2'd2;
          end
        end
        S_FEATURE: begin
          if (vs_rise) begin
            done_q      <= 1'b1;
            frame_cnt_q <= 2'd0;
            pdf_q       <= 1'b0;
            if (cont_mode) begin
              state_q       <= S_PROJ;
              shadow_seen_q <= 1'b0;
              shadow_row_q  <= 4'd0;
              shadow_col_q  <= 4'd0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          frame_cnt_q <= 2'd0;
          pdf_q       <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign frame_cnt         = frame_cnt_q;
  assign project_done_flag = pdf_q;
  assign num_row           = num_row_q;
  assign num_col           = num_col_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign abort             = abort_q;

endmodule

// File: tb/tb_recog_frame_sched.sv
// Testbench for recog_frame_sched: directed scenarios followed by random
// traffic, all checked against a frame-level behavioural model.
module tb_recog_frame_sched;

  localparam int MAX_ROW   = 1;
  localparam int MAX_COL   = 4;
  localparam int MAX_RETRY = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync;
  logic       start;
  logic       cont_mode;
  logic       proj_valid;
  logic [3:0] proj_num_row;
  logic [3:0] proj_num_col;
  logic [1:0] frame_cnt;
  logic       project_done_flag;
  logic [3:0] num_row;
  logic [3:0] num_col;
  logic       busy;
  logic       done;
  logic       err;
  logic       abort;

  int total = 0;
  int bad   = 0;

  recog_frame_sched #(
    .MAX_ROW  (MAX_ROW),
    .MAX_COL  (MAX_COL),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vsync            (vsync),
    .start            (start),
    .cont_mode        (cont_mode),
    .proj_valid       (proj_valid),
    .proj_num_row     (proj_num_row),
    .proj_num_col     (proj_num_col),
    .frame_cnt        (frame_cnt),
    .project_done_flag(project_done_flag),
    .num_row          (num_row),
    .num_col          (num_col),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .abort            (abort)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A run is active between start and its end; it is "synced" once the
  // first vsync edge has been seen. m_frame: 0 projection, 1 border,
  // 2 feature. Pending counts hold the last projection report of a frame.
  bit m_active, m_synced, m_seen;
  int m_frame, m_fails, m_row, m_col;
  int exp_num_row, exp_num_col;
  bit exp_done, exp_err, exp_abort;

  task automatic model_reset();
    m_active = 0; m_synced = 0; m_seen = 0;
    m_frame = 0; m_fails = 0; m_row = 0; m_col = 0;
    exp_num_row = 0; exp_num_col = 0;
    exp_done = 0; exp_err = 0; exp_abort = 0;
  endtask

  task automatic model_start();
    if (!m_active) begin
      m_active = 1; m_synced = 0; exp_abort = 0;
    end
  endtask

  task automatic model_pv(input int r, input int c);
    if (m_active && m_synced && m_frame == 0) begin
      m_seen = 1; m_row = r; m_col = c;
    end
  endtask

  task automatic model_rise(input bit pv_now, input int r, input int c);
    exp_done = 0;
    exp_err  = 0;
    if (!m_active) return;
    if (!m_synced) begin
      m_synced = 1; m_frame = 0; m_seen = 0;
      return;
    end
    case (m_frame)
      0: begin
        if (pv_now) begin m_seen = 1; m_row = r; m_col = c; end
        if (m_seen && m_row >= 1 && m_row <= MAX_ROW && m_col >= 1 && m_col <= MAX_COL) begin
          exp_num_row = m_row; exp_num_col = m_col;
          m_fails = 0; m_frame = 1;
        end else begin
          exp_err = 1;
          m_fails++;
          if (m_fails == MAX_RETRY) begin
            exp_abort = 1; m_active = 0; m_fails = 0;
          end
        end
        m_seen = 0;
      end
      1: m_frame = 2;
      default: begin
        exp_done = 1; m_frame = 0; m_seen = 0;
        if (!cont_mode) m_active = 0;
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input int exp_v);
    total++;
    assert (obs === 8'(exp_v)) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    int fc;
    fc = (m_active && m_synced) ? m_frame : 0;
    check({tag, ".frame_cnt"}, {6'd0, frame_cnt}, fc);
    check({tag, ".pdf"},       {7'd0, project_done_flag}, (fc != 0) ? 1 : 0);
    check({tag, ".busy"},      {7'd0, busy},  m_active ? 1 : 0);
    check({tag, ".done"},      {7'd0, done},  exp_done ? 1 : 0);
    check({tag, ".err"},       {7'd0, err},   exp_err ? 1 : 0);
    check({tag, ".abort"},     {7'd0, abort}, exp_abort ? 1 : 0);
    check({tag, ".num_row"},   {4'd0, num_row}, exp_num_row);
    check({tag, ".num_col"},   {4'd0, num_col}, exp_num_col);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
    exp_done = 0; exp_err = 0;
  endtask

  task automatic pulse_pv(input int r, input int c);
    proj_valid   = 1'b1;
    proj_num_row = 4'(r);
    proj_num_col = 4'(c);
    tick();
    proj_valid = 1'b0;
    model_pv(r, c);
    exp_done = 0; exp_err = 0;
  endtask

  // One vsync frame boundary; the synchronized edge is acted on at the third
  // clock after vsync rises. Optionally a proj_valid lands on that edge.
  task automatic do_rise(input bit coinc, input int r, input int c, input string tag);
    vsync = 1'b1;
    tick();
    tick();
    if (coinc) begin
      proj_valid   = 1'b1;
      proj_num_row = 4'(r);
      proj_num_col = 4'(c);
    end
    tick();
    proj_valid = 1'b0;
    model_rise(coinc, r, c);
    check_all(tag);
    vsync = 1'b0;
    tick();
    exp_done = 0; exp_err = 0;
    check_all({tag, ".after"});
    tick();
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; vsync = 1'b1; start = 1'b0; cont_mode = 1'b0;
    proj_valid = 1'b0; proj_num_row = 4'd0; proj_num_col = 4'd0;
    model_reset();
    repeat (3) tick();
    check_all("reset");

    // Release with vsync already high and start held: the run must wait for
    // a genuine vsync edge, so the first edge below opens the projection frame.
    rst_n = 1'b1;
    start = 1'b1;
    repeat (6) tick();
    start = 1'b0;
    model_start();
    check_all("release");
    vsync = 1'b0;
    repeat (3) tick();

    // Nominal single run.
    do_rise(0, 0, 0, "nom.sync");
    pulse_pv(1, 4);
    do_rise(0, 0, 0, "nom.proj");
    pulse_pv(0, 7);
    do_rise(0, 0, 0, "nom.border");
    pulse_pv(1, 2);
    do_rise(0, 0, 0, "nom.feature");
    tick();
    check_all("nom.idle");

    // Reject an out-of-range column, then accept a retry.
    pulse_start();
    do_rise(0, 0, 0, "rej.sync");
    pulse_pv(1, 5);
    do_rise(0, 0, 0, "rej.bad");
    pulse_pv(1, 3);
    do_rise(0, 0, 0, "rej.retry");
    do_rise(0, 0, 0, "rej.border");
    do_rise(0, 0, 0, "rej.feature");

    // Abort after repeated empty projection frames; next start clears it.
    pulse_start();
    do_rise(0, 0, 0, "abt.sync");
    for (int i = 0; i < MAX_RETRY; i++) do_rise(0, 0, 0, $sformatf("abt.miss%0d", i));
    pulse_start();
    check_all("abt.restart");
    do_rise(0, 0, 0, "abt.sync2");
    pulse_pv(1, 1);
    do_rise(0, 0, 0, "abt.proj");
    do_rise(0, 0, 0, "abt.border");
    do_rise(0, 0, 0, "abt.feature");

    // proj_valid on the closing edge counts, and overrides an earlier report.
    pulse_start();
    do_rise(0, 0, 0, "coi.sync");
    pulse_pv(1, 9);
    do_rise(1, 1, 2, "coi.proj");
    do_rise(0, 0, 0, "coi.border");
    do_rise(0, 0, 0, "coi.feature");

    // Continuous mode over 7 edges, then drop out on the next feature exit.
    cont_mode = 1'b1;
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      if (m_synced && m_frame == 0) pulse_pv(1, 1 + (i % 4));
      do_rise(0, 0, 0, $sformatf("cont.%0d", i));
    end
    cont_mode = 1'b0;
    for (int i = 0; i < 4 && m_active; i++) begin
      if (m_frame == 0) pulse_pv(1, 4);
      do_rise(0, 0, 0, $sformatf("cont.end%0d", i));
    end

    // Reset in the middle of a feature frame.
    pulse_start();
    do_rise(0, 0, 0, "mrst.sync");
    pulse_pv(1, 3);
    do_rise(0, 0, 0, "mrst.proj");
    do_rise(0, 0, 0, "mrst.border");
    check_all("mrst.feature");
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mrst.asserted");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check_all("mrst.released");
    do_rise(0, 0, 0, "mrst.nodone");

    // Random traffic against the model.
    for (int it = 0; it < 200; it++) begin
      int npv;
      bit coinc;
      if (!m_active && ($urandom % 2 == 0)) pulse_start();
      else if ($urandom % 10 == 0) pulse_start();
      npv = $urandom_range(0, 2);
      for (int k = 0; k < npv; k++) pulse_pv($urandom_range(0, 2), $urandom_range(0, 6));
      cont_mode = ($urandom % 3 != 0);
      coinc = ($urandom % 4 == 0);
      do_rise(coinc, $urandom_range(0, 2), $urandom_range(0, 6), $sformatf("rnd.%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/recog_frame_sched.md
RECOG_FRAME_SCHED -- requirements
Module: recog_frame_sched

Interface
REQ-001 SHALL have parameter MAX_ROW, default 1: maximum digit rows accepted from projection.
REQ-002 SHALL have parameter MAX_COL, default 4: maximum digit columns accepted from projection.
REQ-003 SHALL have parameter MAX_RETRY, default 3: projection frames attempted before abort.
REQ-004 SHALL have port clk  input  1: single clock; all state sampled on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port vsync  input  1: active-high frame sync level, asynchronous to clk.
REQ-007 SHALL have port start  input  1: one-cycle request to begin a recognition run.
REQ-008 SHALL have port cont_mode  input  1: 1 = loop runs continuously; 0 = single run.
REQ-009 SHALL have port proj_valid  input  1: one-cycle pulse; projection counts are valid.
REQ-010 SHALL have port proj_num_row  input  4: row count from projection.
REQ-011 SHALL have port proj_num_col  input  4: column count from projection.
REQ-012 SHALL have port frame_cnt  output  2: frame phase (0 projection, 1 border, 2 feature).
REQ-013 SHALL have port project_done_flag  output  1: high during border and feature frames.
REQ-014 SHALL have port num_row  output  4: latched row count for the recognizer.
REQ-015 SHALL have port num_col  output  4: latched column count for the recognizer.
REQ-016 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-017 SHALL have port done  output  1: one-cycle pulse at the end of each feature frame.
REQ-018 SHALL have port err  output  1: one-cycle pulse on a rejected projection frame.
REQ-019 SHALL have port abort  output  1: sticky flag after MAX_RETRY rejections; cleared by start.

Function
REQ-020 SHALL synchronize vsync through two flops, then register once more for edge detection; vs_rise asserts 3 clk after the input rises.
REQ-021 SHALL implement states IDLE, WAIT_SYNC, PROJ, BORDER and FEATURE.
REQ-022 SHALL go IDLE->WAIT_SYNC on start; start outside IDLE SHALL be ignored.
REQ-023 SHALL go WAIT_SYNC->PROJ on vs_rise.
REQ-024 SHALL, in PROJ, capture proj_num_row/col into a shadow on proj_valid; the last pulse in the frame wins.
REQ-025 SHALL, on vs_rise in PROJ, accept the shadow if proj_valid was seen, 1<=row<=MAX_ROW and 1<=col<=MAX_COL.
REQ-026 SHALL, on acceptance, copy the shadow to num_row/num_col, clear the retry count and go to BORDER.
REQ-027 SHALL, on rejection, pulse err, increment the retry count and stay in PROJ.
REQ-028 SHALL, when the retry count reaches MAX_RETRY, set abort and go to IDLE.
REQ-029 SHALL go BORDER->FEATURE on vs_rise.
REQ-030 SHALL, on vs_rise in FEATURE, pulse done, then go to PROJ if cont_mode is 1, else IDLE.
REQ-031 SHALL drive frame_cnt from registers: 0 in IDLE, WAIT_SYNC and PROJ; 1 in BORDER; 2 in FEATURE; never 3.
REQ-032 SHALL drive project_done_flag as a registered output, 1 exactly in BORDER and FEATURE.
REQ-033 SHALL update frame_cnt, project_done_flag and state in the same cycle that vs_rise is acted on.
REQ-034 SHALL hold num_row/num_col stable through BORDER and FEATURE; proj_valid in those states is ignored.
REQ-035 SHALL, when proj_valid coincides with vs_rise in PROJ, count that pulse toward the frame being closed.
REQ-036 SHALL sample cont_mode only at the FEATURE exit.
REQ-037 SHALL clear the shadow and its seen flag on every entry to PROJ.
REQ-038 SHALL keep the retry counter wide enough for MAX_RETRY with no wrap.

Reset
REQ-039 SHALL, on rst_n low at any time including mid-run, immediately set state=IDLE, frame_cnt=0, project_done_flag=0, num_row=0, num_col=0, busy=0, done=0, err=0, abort=0, retry=0, sync flops=0.
REQ-040 SHALL release reset synchronously to clk; a vsync already high at release SHALL NOT produce vs_rise.

Verification
REQ-041 SHALL verify nominal single run: start, then 4 vsync rises with proj_valid row=1 col=4 in the PROJ frame -> frame_cnt 0,0,1,2, then IDLE; done pulses once; num_row=1, num_col=4.
REQ-042 SHALL verify reject: proj_valid with col=5 (MAX_COL=4) -> err pulse at frame end, frame_cnt stays 0; a valid retry proceeds to 1.
REQ-043 SHALL verify abort: 3 PROJ frames with no proj_valid -> 3 err pulses, then abort=1, busy=0; the next start clears abort.
REQ-044 SHALL verify continuous mode: cont_mode=1 over 7 vsync rises -> frame_cnt sequence 0,1,2,0,1,2 with 2 done pulses.
REQ-045 SHALL verify mid-run reset: rst_n low during FEATURE -> all outputs 0 within the reset assertion; no done pulse follows.
REQ-046 SHALL verify coincidence: proj_valid in the same cycle as vs_rise in PROJ -> counts accepted and frame_cnt becomes 1 on that edge.
